mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (IF) and the memory stage (DM).
- Sequences each access with a registered req/ack handshake to memory.
- Produces per-stage stall requests that the pipeline hazard logic ORs into stallF/stallD and the M-stage hold.
- Honours branch flushes by cancelling in-flight fetch results.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- BE_W, DATA_W/8, byte-enable width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  fetch complete, one cycle
- flush_if  in  1  branch flush; cancels the pending fetch
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  BE_W  store byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  data access complete, one cycle
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  BE_W  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion
- stall_if  out  1  fetch not yet served
- stall_mem  out  1  data access not yet served

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - On reset, the FSM goes to IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, dm_valid and the cancel flag are all 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - Arbitrate on the current requests. dm_req beats if_req (the older instruction wins; this avoids deadlock).
  - The winner's addr/we/be/wdata are latched into the mem_* registers. mem_req=1 from the next cycle.
  - For a fetch, mem_we=0 and mem_be=all ones.
- BUSY_x:
  - mem_req and the mem_* fields are held stable until mem_ack.
  - On the mem_ack cycle, x_valid=1 combinationally and x_rdata=mem_rdata pass-through.
  - On the ack edge, mem_req drops.
- Re-arbitration after ack:
  - On the ack cycle, the other requester may be granted directly (next state BUSY_other, mem_req stays 1 with new fields).
  - Otherwise, return to IDLE. The same requester is never re-granted on its own ack cycle, because its req is stale.
- Minimum access cost is 2 cycles (grant + ack). Latency = 1 + memory wait cycles.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid_visible.
  - stall_mem = dm_req & ~dm_valid.
  - Both are 0 in reset.
- Flush:
  - flush_if in BUSY_IF sets cancel. The transaction still completes on the memory side, but if_valid is suppressed at ack and cancel clears.
  - flush_if on the ack cycle itself suppresses if_valid that cycle.
  - flush_if in IDLE or BUSY_DM has no effect, except that an if_req in the same cycle is ignored for arbitration.
- mem_ack outside BUSY is ignored. A store completes with dm_valid=1; dm_rdata is don't-care.
- Reset mid-transaction aborts immediately. Memory-side recovery is the memory's responsibility.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds a 32-bit output if_conflict_cnt. It increments each cycle that if_req=1 while the FSM is BUSY_DM or dm wins arbitration in IDLE.
  - Saturates at 0xFFFFFFFF; reset to 0.
  - Also adds output mem_busy_cnt (32-bit, counts mem_req=1 cycles).
- Undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Test Plan:
- Lone fetch, if_addr=0x100, mem_ack 2 cycles after mem_req → mem_req cycle 1, if_valid at cycle 3 with mem_rdata; stall_if=1 for cycles 0–2.
- Simultaneous if_req and dm_req (load 0x2000) in IDLE → DM granted first. On the DM ack cycle, IF is granted directly (mem_addr=if_addr next cycle, no IDLE gap); stall_if stays high throughout.
- Store dm_we=1, dm_be=4'b0011, wdata=0xDEADBEEF → mem_we=1, mem_be=0011, mem_wdata stable until ack; dm_valid=1 on ack.
- flush_if pulse while BUSY_IF, with ack 3 cycles later → no if_valid, FSM returns to IDLE. The same check applies with flush_if coincident with mem_ack.
- rst_n low for one cycle mid BUSY_DM → all outputs 0 asynchronously, IDLE after release; a pending dm_req is re-granted.
- With ARB_PERF_EN, 3 cycles of IF blocked behind DM → if_conflict_cnt=3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-ported memory between fetch (IF) and data (DM) stages.
// Define ARB_PERF_EN to add saturating if_conflict_cnt / mem_busy_cnt counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              flush_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [BE_W-1:0]   dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
`ifdef ARB_PERF_EN
    output logic [31:0]       if_conflict_cnt,
    output logic [31:0]       mem_busy_cnt,
`endif
    output logic              stall_if,
    output logic              stall_mem
);

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t   state, state_nxt;
    mem_cmd_t cmd_q, cmd_if, cmd_dm;
    logic     grant_if, grant_dm, ack_if, ack_dm, cancel;

    assign cmd_if = '{we: 1'b0, be: {BE_W{1'b1}}, addr: if_addr, wdata: {DATA_W{1'b0}}};
    assign cmd_dm = '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
    assign ack_if = (state == BUSY_IF) & mem_ack;
    assign ack_dm = (state == BUSY_DM) & mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The requester being acked presents a stale req, so only the other side may chain.
    always_comb begin
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_req)                  grant_dm = 1'b1;
                else if (if_req && !flush_if) grant_if = 1'b1;
            end
            BUSY_IF: if (mem_ack && dm_req) grant_dm = 1'b1;
            BUSY_DM: if (mem_ack && if_req && !flush_if) grant_if = 1'b1;
            default: ;
        endcase
        if (grant_dm)                        state_nxt = BUSY_DM;
        else if (grant_if)                   state_nxt = BUSY_IF;
        else if (mem_ack && state != IDLE)   state_nxt = IDLE;
    end

    always_comb begin
        if_valid  = ack_if & ~cancel & ~flush_if;
        dm_valid  = ack_dm;
        stall_if  = rst_n & if_req & ~if_valid;
        stall_mem = rst_n & dm_req & ~dm_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            cancel <= 1'b0;
        end else begin
            if (grant_dm)      cmd_q <= cmd_dm;
            else if (grant_if) cmd_q <= cmd_if;
            if (ack_if)                              cancel <= 1'b0;
            else if (state == BUSY_IF && flush_if)   cancel <= 1'b1;
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = cmd_q.we;
    assign mem_be    = cmd_q.be;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

`ifdef ARB_PERF_EN
    logic if_blocked;
    assign if_blocked = if_req & ((state == BUSY_DM) | ((state == IDLE) & dm_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_conflict_cnt <= '0;
            mem_busy_cnt    <= '0;
        end else begin
            if (if_blocked && if_conflict_cnt != 32'hFFFF_FFFF) if_conflict_cnt <= if_conflict_cnt + 32'd1;
            if (mem_req && mem_busy_cnt != 32'hFFFF_FFFF)       mem_busy_cnt    <= mem_busy_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: transaction-level memory/requester model with per-cycle checks.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, BW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0, flush_if = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic [BW-1:0] dm_be = '0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic          if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem;
`ifdef ARB_PERF_EN
    logic [31:0]   if_conflict_cnt, mem_busy_cnt;
`endif

    int checks = 0, failures = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .flush_if(flush_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef ARB_PERF_EN
        .if_conflict_cnt(if_conflict_cnt), .mem_busy_cnt(mem_busy_cnt),
`endif
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Reference model state: requester intents, the transaction the memory should see, memory contents.
    logic [31:0] mem_m [logic [29:0]];
    bit          if_pend, dm_pend, busy, cancel_m, owner_dm, flush_now, spur_en;
    logic [31:0] if_a, dm_a, dm_wd, x_addr, x_wd;
    logic        dm_w, x_we;
    logic [3:0]  dm_b, x_be;
    int          wait_left, force_wait = -1, cyc = 0, ifv_cyc = -1, ifv_seen = 0, dmv_seen = 0;
    logic [31:0] conf_m = 0, busy_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a[31:2])) return mem_m[a[31:2]];
        return {a[15:0] ^ 16'h5a5a, a[15:0]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        r = 32'($urandom_range(0, 255)) << 2;
        return r;
    endfunction

    // One clock cycle: enter at posedge+1, drive, check at negedge, advance model, leave at posedge+1.
    task automatic tick();
        bit ack, exp_ifv, exp_dmv, g_dm, g_if;
        logic [31:0] nv, old;
        ack = busy && (wait_left == 0);
        if_req = if_pend; if_addr = if_a;
        dm_req = dm_pend; dm_we = dm_w; dm_be = dm_b; dm_addr = dm_a; dm_wdata = dm_wd;
        flush_if = flush_now;
        mem_ack = ack || (!busy && spur_en && ($urandom_range(0, 3) == 0));
        mem_rdata = (ack && !x_we) ? rd(x_addr) : $urandom;
        @(negedge clk);
        exp_ifv = ack && !owner_dm && !cancel_m && !flush_now;
        exp_dmv = ack && owner_dm;
        chk("mem_req", 32'(mem_req), 32'(busy));
        if (busy) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_we", 32'(mem_we), 32'(x_we));
            chk("mem_be", 32'(mem_be), 32'(x_be));
            if (x_we) chk("mem_wdata", mem_wdata, x_wd);
        end
        chk("if_valid", 32'(if_valid), 32'(exp_ifv));
        chk("dm_valid", 32'(dm_valid), 32'(exp_dmv));
        if (exp_ifv) chk("if_rdata", if_rdata, rd(x_addr));
        if (exp_dmv && !x_we) chk("dm_rdata", dm_rdata, rd(x_addr));
        chk("stall_if", 32'(stall_if), 32'(if_pend && !exp_ifv));
        chk("stall_mem", 32'(stall_mem), 32'(dm_pend && !exp_dmv));
`ifdef ARB_PERF_EN
        chk("if_conflict_cnt", if_conflict_cnt, conf_m);
        chk("mem_busy_cnt", mem_busy_cnt, busy_m);
        if (if_pend && ((busy && owner_dm) || (!busy && dm_pend)) && conf_m != 32'hFFFF_FFFF) conf_m++;
        if (busy && busy_m != 32'hFFFF_FFFF) busy_m++;
`endif
        if (if_valid === 1'b1) begin ifv_cyc = cyc; ifv_seen++; end
        if (dm_valid === 1'b1) dmv_seen++;
        if (exp_dmv && x_we) begin
            old = rd(x_addr);
            nv = old;
            for (int b = 0; b < 4; b++) if (x_be[b]) nv[b*8 +: 8] = x_wd[b*8 +: 8];
            mem_m[x_addr[31:2]] = nv;
        end
        // A grant opportunity exists when idle or on an ack; the acked side cannot win it.
        g_dm = (!busy || ack) && dm_pend && !(ack && owner_dm);
        g_if = (!busy || ack) && !g_dm && if_pend && !flush_now && !(ack && !owner_dm);
        if (exp_ifv) if_pend = 0;
        if (exp_dmv) dm_pend = 0;
        if (g_dm || g_if) begin
            busy = 1; owner_dm = g_dm; cancel_m = 0;
            x_addr = g_dm ? dm_a : if_a;
            x_we   = g_dm && dm_w;
            x_be   = g_dm ? dm_b : 4'hF;
            x_wd   = dm_wd;
            wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        end else if (ack) begin
            busy = 0; cancel_m = 0;
        end else if (busy) begin
            wait_left--;
            if (!owner_dm && flush_now) cancel_m = 1;
        end
        flush_now = 0;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run_idle(input int limit);
        int n = 0;
        while ((if_pend || dm_pend || busy) && n < limit) begin tick(); n++; end
        chk("drain_timeout", 32'(if_pend || dm_pend || busy), 32'd0);
        tick();
    endtask

    task automatic mid_reset();
        mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst mem_req", 32'(mem_req), 0);
        chk("arst mem_we", 32'(mem_we), 0);
        chk("arst mem_be", 32'(mem_be), 0);
        chk("arst mem_addr", mem_addr, 0);
        chk("arst mem_wdata", mem_wdata, 0);
        chk("arst if_valid", 32'(if_valid), 0);
        chk("arst dm_valid", 32'(dm_valid), 0);
        chk("arst stall_mem", 32'(stall_mem), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        busy = 0; cancel_m = 0; conf_m = 0; busy_m = 0;
    endtask

    initial begin
        int start, seen;
        // Reset state, with requests asserted to show stalls are gated.
        if_req = 1'b1; dm_req = 1'b1;
        #3;
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst if_valid", 32'(if_valid), 0);
        chk("rst dm_valid", 32'(dm_valid), 0);
        chk("rst stall_if", 32'(stall_if), 0);
        chk("rst stall_mem", 32'(stall_mem), 0);
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Lone fetch, ack two cycles after mem_req: if_valid expected at cycle 3.
        force_wait = 2;
        if_pend = 1; if_a = 32'h100;
        start = cyc;
        run_idle(20);
        chk("fetch latency", 32'(ifv_cyc - start), 32'd3);

        // Simultaneous load and fetch: DM first, IF chained on the DM ack.
        force_wait = 1;
        dm_pend = 1; dm_w = 0; dm_b = 4'hF; dm_a = 32'h2000; dm_wd = 32'h0;
        if_pend = 1; if_a = 32'h104;
        run_idle(20);

        // Partial store then read back the merged word.
        force_wait = 2;
        dm_pend = 1; dm_w = 1; dm_b = 4'b0011; dm_a = 32'h40; dm_wd = 32'hDEADBEEF;
        run_idle(20);
        dm_pend = 1; dm_w = 0; dm_b = 4'hF; dm_a = 32'h40;
        run_idle(20);
        chk("store merge", rd(32'h40), {16'h5a1a, 16'hBEEF});

        // Flush mid BUSY_IF, ack three cycles later: no if_valid.
        force_wait = 3;
        seen = ifv_seen;
        if_pend = 1; if_a = 32'h300;
        tick(); tick();
        flush_now = 1; if_pend = 0;
        run_idle(20);
        chk("flush mid no if_valid", 32'(ifv_seen - seen), 32'd0);

        // Flush coincident with ack.
        force_wait = 1;
        seen = ifv_seen;
        if_pend = 1; if_a = 32'h304;
        tick(); tick();
        flush_now = 1;
        tick();
        if_pend = 0;
        run_idle(20);
        chk("flush at ack no if_valid", 32'(ifv_seen - seen), 32'd0);

        // Reset mid BUSY_DM; the held load must be re-granted and completed.
        force_wait = 3;
        seen = dmv_seen;
        dm_pend = 1; dm_w = 0; dm_b = 4'hF; dm_a = 32'h2000;
        tick(); tick();
        mid_reset();
        run_idle(20);
        chk("regrant after reset", 32'(dmv_seen - seen), 32'd1);

        // Randomized traffic with redirecting flushes and spurious acks while idle.
        force_wait = -1;
        spur_en = 1;
        for (int i = 0; i < 400; i++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_a = rnd_addr(); end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_w = 1'($urandom_range(0, 1)); dm_b = 4'($urandom_range(1, 15));
                dm_a = rnd_addr(); dm_wd = $urandom;
            end
            if ($urandom_range(0, 7) == 0) begin
                flush_now = 1;
                if (if_pend) if_a = rnd_addr();
            end
            tick();
        end
        spur_en = 0;
        run_idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
